risc_core_p: RTL and testbench

- Parametrised, multi-cycle accumulator processor; successor to the fixed 8-bit/5-bit-address core.
- Same 8-opcode ISA: HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP.
- New over the previous core:
  - generic data/address widths;
  - ready/ack memory handshake with arbitrary wait states;
  - carry flag on ADD;
  - resume-from-halt input.
- Sits between the top level and a single unified instruction/data memory.

---
 rtl/risc_core_p.sv | 196 +++++++++++++++++++
 tb/tb_risc_core_p.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/risc_core_p.sv
// risc_core_p -- multi-cycle accumulator processor with a unified memory port.
//
// Every instruction passes through FETCH -> DECODE -> EXEC. FETCH and the
// memory-referencing EXEC opcodes issue one request each and hold it until
// mem_ack. With zero-wait memory each instruction takes 3 cycles.
//
// Parameters
//   DWIDTH  data / instruction width (must be >= AWIDTH+3)
//   AWIDTH  address / PC width
//   RST_PC  PC value loaded by reset
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset; also drops any open request
//   run        one-cycle pulse that resumes a halted core
//   mem_req    transaction request, held until mem_ack
//   mem_we     1 = write, 0 = read (valid with mem_req)
//   mem_addr   transaction address (valid with mem_req)
//   mem_wdata  write data, always the accumulator
//   mem_rdata  read data, taken in the mem_ack cycle
//   mem_ack    transaction complete (may coincide with mem_req)
//   halt       core halted
//   carry      carry-out of the most recent ADD
//   pc         current program counter
module risc_core_p #(
    parameter int                DWIDTH = 8,
    parameter int                AWIDTH = 5,
    parameter logic [AWIDTH-1:0] RST_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic              mem_req,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              halt,
    output logic              carry,
    output logic [AWIDTH-1:0] pc
);

    // The opcode field sits above the operand address; they must not overlap.
    if (DWIDTH < AWIDTH + 3) begin : g_bad_width
        $error("risc_core_p: DWIDTH must be >= AWIDTH+3");
    end

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    typedef enum logic [1:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;

    state_t              state_reg, state_next;
    logic [AWIDTH-1:0]   pc_reg, pc_next;
    logic [DWIDTH-1:0]   ac_reg, ac_next;
    logic [DWIDTH-1:0]   ir_reg, ir_next;
    logic                carry_reg, carry_next;

    logic                req_c;
    logic                we_c;
    logic [AWIDTH-1:0]   addr_c;

    logic [2:0]          opcode;
    logic [AWIDTH-1:0]   operand;
    logic [DWIDTH:0]     add_sum;
    logic [DWIDTH-1:0]   and_bits;
    logic [DWIDTH-1:0]   xor_bits;
    logic                unused_ir;

    assign opcode  = ir_reg[DWIDTH-1 -: 3];
    assign operand = ir_reg[AWIDTH-1:0];
    // Bits between the opcode and the operand carry no meaning.
    assign unused_ir = ^ir_reg;

    // One extra bit on the adder captures the carry out of DWIDTH.
    assign add_sum = {1'b0, ac_reg} + {1'b0, mem_rdata};

    for (genvar gi = 0; gi < DWIDTH; gi++) begin : g_logic_unit
        assign and_bits[gi] = ac_reg[gi] & mem_rdata[gi];
        assign xor_bits[gi] = ac_reg[gi] ^ mem_rdata[gi];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_FETCH;
            pc_reg    <= RST_PC;
            ac_reg    <= '0;
            ir_reg    <= '0;
            carry_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ac_reg    <= ac_next;
            ir_reg    <= ir_next;
            carry_reg <= carry_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ac_next    = ac_reg;
        ir_next    = ir_reg;
        carry_next = carry_reg;
        req_c      = 1'b0;
        we_c       = 1'b0;
        addr_c     = pc_reg;

        case (state_reg)
            S_FETCH: begin
                req_c  = 1'b1;
                addr_c = pc_reg;
                if (mem_ack) begin
                    ir_next    = mem_rdata;
                    state_next = S_DECODE;
                end
            end

            S_DECODE: begin
                pc_next    = pc_reg + AWIDTH'(1);
                state_next = S_EXEC;
            end

            S_EXEC: begin
                case (opcode)
                    OP_HLT: state_next = S_HALT;
                    OP_SKZ: begin
                        // AC cannot change before EXEC completes, so this is
                        // the value it held on entry.
                        if (ac_reg == '0) begin
                            pc_next = pc_reg + AWIDTH'(1);
                        end
                        state_next = S_FETCH;
                    end
                    OP_JMP: begin
                        pc_next    = operand;
                        state_next = S_FETCH;
                    end
                    OP_STO: begin
                        req_c  = 1'b1;
                        we_c   = 1'b1;
                        addr_c = operand;
                        if (mem_ack) begin
                            state_next = S_FETCH;
                        end
                    end
                    default: begin
                        // ADD / AND / XOR / LDA: operand read.
                        req_c  = 1'b1;
                        addr_c = operand;
                        if (mem_ack) begin
                            state_next = S_FETCH;
                            case (opcode)
                                OP_ADD: {carry_next, ac_next} = add_sum;
                                OP_AND: ac_next = and_bits;
                                OP_XOR: ac_next = xor_bits;
                                default: ac_next = mem_rdata;
                            endcase
                        end
                    end
                endcase
            end

            S_HALT: begin
                if (run) begin
                    state_next = S_FETCH;
                end
            end

            default: state_next = S_FETCH;
        endcase
    end

    // Reset is synchronous, so the registered state may still be stale during
    // the rst cycle; gate the externally visible controls directly.
    assign mem_req   = req_c & ~rst;
    assign mem_we    = we_c;
    assign mem_addr  = addr_c;
    assign mem_wdata = ac_reg;
    assign halt      = (state_reg == S_HALT) & ~rst;
    assign carry     = carry_reg;
    assign pc        = pc_reg;

endmodule

// File: tb/tb_risc_core_p.sv
// Testbench for risc_core_p: an 8/5 instance with a wait-state memory model
// and a 16/10 instance with zero-wait memory. Expected memory transactions are
// queued when each program is loaded; monitors pop and compare them as the
// DUTs complete transactions.
module tb_risc_core_p;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- 8-bit / 5-bit instance ----------------
    logic       rst8 = 1'b1, run8 = 1'b0;
    logic       req8, we8, ack8, halt8, carry8;
    logic [4:0] addr8, pc8;
    logic [7:0] wdata8, rdata8;

    risc_core_p #(.DWIDTH(8), .AWIDTH(5), .RST_PC(5'd0)) dut8 (
        .clk(clk), .rst(rst8), .run(run8),
        .mem_req(req8), .mem_we(we8), .mem_addr(addr8), .mem_wdata(wdata8),
        .mem_rdata(rdata8), .mem_ack(ack8),
        .halt(halt8), .carry(carry8), .pc(pc8)
    );

    // ---------------- 16-bit / 10-bit instance ----------------
    logic       rst16 = 1'b1, run16 = 1'b0;
    logic       req16, we16, ack16, halt16, carry16;
    logic [9:0] addr16, pc16;
    logic [15:0] wdata16, rdata16;

    risc_core_p #(.DWIDTH(16), .AWIDTH(10), .RST_PC(10'h3FD)) dut16 (
        .clk(clk), .rst(rst16), .run(run16),
        .mem_req(req16), .mem_we(we16), .mem_addr(addr16), .mem_wdata(wdata16),
        .mem_rdata(rdata16), .mem_ack(ack16),
        .halt(halt16), .carry(carry16), .pc(pc16)
    );

    // ---------------- memory models ----------------
    logic [7:0]  mem8  [32];
    logic [15:0] mem16 [1024];
    int          wait_cnt = 0, wait_tgt = 0, max_wait = 0;
    logic        blk_en = 1'b0;
    logic [4:0]  blk_addr = 5'd0;

    assign ack8   = req8 && (max_wait == 0 || wait_cnt >= wait_tgt)
                    && !(blk_en && addr8 == blk_addr);
    assign rdata8 = mem8[addr8];

    always @(posedge clk) begin
        if (req8 && ack8) begin
            if (we8) mem8[addr8] = wdata8;
            wait_cnt <= 0;
            wait_tgt <= int'($urandom_range(max_wait, 0));
        end else if (req8) begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    assign ack16   = req16;
    assign rdata16 = mem16[addr16];

    always @(posedge clk) begin
        if (req16 && ack16 && we16) mem16[addr16] = wdata16;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        we;
        logic [9:0]  addr;
        logic [15:0] data;
        logic        fetch;
    } txn_t;
    txn_t exp_q[$];

    task automatic push(input logic we, input logic [9:0] a, input logic [15:0] d, input logic f);
        txn_t t;
        t.we = we; t.addr = a; t.data = d; t.fetch = f;
        exp_q.push_back(t);
    endtask
    task automatic push_f(input logic [9:0] a);                   push(1'b0, a, 16'h0, 1'b1); endtask
    task automatic push_r(input logic [9:0] a);                   push(1'b0, a, 16'h0, 1'b0); endtask
    task automatic push_w(input logic [9:0] a, input logic [15:0] d); push(1'b1, a, d, 1'b0); endtask

    task automatic sb_compare(input string who, input logic we, input logic [9:0] a,
                              input logic [15:0] d, output logic was_fetch);
        txn_t e;
        checks++;
        was_fetch = 1'b0;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s txn_unexpected actual we=%0b addr=%h data=%h required none", who, we, a, d);
        end else begin
            e = exp_q.pop_front();
            was_fetch = e.fetch;
            if (e.we !== we || e.addr !== a || (we && e.data !== d)) begin
                failures++;
                $display("FAIL %s txn actual we=%0b addr=%h data=%h required we=%0b addr=%h data=%h",
                         who, we, a, d, e.we, e.addr, e.data);
            end else begin
                $display("txn %s %s addr=%h data=%h", who, we ? "W" : (e.fetch ? "F" : "R"), a,
                         we ? d : 16'h0);
            end
        end
    endtask

    // Monitor for the 8-bit instance: scoreboard plus handshake stability and
    // "no request in DECODE" (the cycle right after a fetch completes).
    logic       prev_pending = 1'b0, prev_we = 1'b0, expect_idle = 1'b0;
    logic [4:0] prev_addr = 5'd0;
    logic [7:0] prev_wdata = 8'd0;

    always @(negedge clk) begin
        logic f;
        if (prev_pending && !rst8) begin
            checks++;
            if (!(req8 && we8 == prev_we && addr8 == prev_addr && (!prev_we || wdata8 == prev_wdata))) begin
                failures++;
                $display("FAIL hold_stable actual req=%0b we=%0b addr=%h wdata=%h required 1 %0b %h %h",
                         req8, we8, addr8, wdata8, prev_we, prev_addr, prev_wdata);
            end
        end
        if (expect_idle && !rst8) begin
            checks++;
            if (req8) begin
                failures++;
                $display("FAIL decode_idle actual mem_req=%0b required 0", req8);
            end
        end
        expect_idle  = 1'b0;
        prev_pending = req8 && !ack8 && !rst8;
        prev_we      = we8;
        prev_addr    = addr8;
        prev_wdata   = wdata8;
        if (req8 && ack8) begin
            sb_compare("dut8", we8, {5'd0, addr8}, {8'd0, wdata8}, f);
            expect_idle = f;
        end
    end

    always @(negedge clk) begin
        logic f;
        if (req16 && ack16) sb_compare("dut16", we16, addr16, wdata16, f);
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset8();
        rst8 = 1'b1;
        run8 = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 32; i++) mem8[i] = 8'h00;
    endtask

    task automatic wait_halt8(input string name, input int budget);
        int n = 0;
        while (!halt8 && n < budget) begin
            tick();
            n++;
        end
        check({name, "_halt_reached"}, {31'd0, halt8}, 32'd1);
    endtask

    task automatic queue_drained(input string name);
        check({name, "_queue_left"}, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    task automatic load_main_program();
        mem8[0]    = 8'hBE;   // LDA 0x1E
        mem8[1]    = 8'h5F;   // ADD 0x1F
        mem8[2]    = 8'hDD;   // STO 0x1D
        mem8[3]    = 8'h00;   // HLT
        mem8[5'h1E] = 8'h05;
        mem8[5'h1F] = 8'hFE;
        push_f(10'h0); push_r(10'h1E);
        push_f(10'h1); push_r(10'h1F);
        push_f(10'h2); push_w(10'h1D, 16'h0003);
        push_f(10'h3);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int  n;
        logic any_req;

        // Reset state
        reset8();
        check("rst_req", {31'd0, req8}, 32'd0);
        check("rst_halt", {31'd0, halt8}, 32'd0);
        check("rst_pc", {27'd0, pc8}, 32'd0);
        check("rst_carry", {31'd0, carry8}, 32'd0);

        // 1. Zero-wait program with exact cycle count
        load_main_program();
        rst8 = 1'b0;
        repeat (11) tick();
        check("zw_halt_at_11", {31'd0, halt8}, 32'd0);
        tick();
        check("zw_halt_at_12", {31'd0, halt8}, 32'd1);
        check("zw_mem1d", {24'd0, mem8[5'h1D]}, 32'h03);
        check("zw_carry", {31'd0, carry8}, 32'd1);
        check("zw_pc", {27'd0, pc8}, 32'd4);
        queue_drained("zw");

        // 2. Same program with random wait states
        reset8();
        max_wait = 3;
        load_main_program();
        rst8 = 1'b0;
        wait_halt8("ws", 200);
        check("ws_mem1d", {24'd0, mem8[5'h1D]}, 32'h03);
        check("ws_carry", {31'd0, carry8}, 32'd1);
        check("ws_pc", {27'd0, pc8}, 32'd4);
        queue_drained("ws");
        max_wait = 0;

        // 3a. SKZ with AC=0 skips the JMP
        reset8();
        mem8[0] = 8'h20;      // SKZ
        mem8[1] = 8'hF0;      // JMP 0x10
        mem8[2] = 8'h00;      // HLT
        push_f(10'h0); push_f(10'h2);
        rst8 = 1'b0;
        wait_halt8("skz0", 50);
        check("skz0_pc", {27'd0, pc8}, 32'd3);
        queue_drained("skz0");

        // 3b. SKZ with AC=1 lets the JMP through
        reset8();
        mem8[0] = 8'hBE;      // LDA 0x1E
        mem8[1] = 8'h20;      // SKZ
        mem8[2] = 8'hF0;      // JMP 0x10
        mem8[3] = 8'h00;      // HLT
        mem8[5'h10] = 8'h00;  // HLT
        mem8[5'h1E] = 8'h01;
        push_f(10'h0); push_r(10'h1E); push_f(10'h1); push_f(10'h2); push_f(10'h10);
        rst8 = 1'b0;
        wait_halt8("skz1", 50);
        check("skz1_pc", {27'd0, pc8}, 32'h11);
        queue_drained("skz1");

        // 4. Halt at 0x07, stay quiet, resume with run
        reset8();
        mem8[0] = 8'hE7;      // JMP 0x07
        mem8[7] = 8'h00;      // HLT
        mem8[8] = 8'hBE;      // LDA 0x1E
        mem8[9] = 8'hDD;      // STO 0x1D
        mem8[10] = 8'h00;     // HLT
        mem8[5'h1E] = 8'h5A;
        push_f(10'h0); push_f(10'h7);
        rst8 = 1'b0;
        wait_halt8("hlt", 50);
        any_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (req8 || !halt8) any_req = 1'b1;
        end
        check("hlt_quiet_20", {31'd0, any_req}, 32'd0);
        check("hlt_pc", {27'd0, pc8}, 32'd8);
        push_f(10'h8); push_r(10'h1E); push_f(10'h9); push_w(10'h1D, 16'h005A); push_f(10'hA);
        run8 = 1'b1;
        tick();
        run8 = 1'b0;
        check("run_fetch_req", {31'd0, req8}, 32'd1);
        check("run_fetch_addr", {27'd0, addr8}, 32'h08);
        check("run_halt_low", {31'd0, halt8}, 32'd0);
        tick();
        run8 = 1'b1;          // ignored while running
        tick();
        run8 = 1'b0;
        wait_halt8("resume", 50);
        check("resume_pc", {27'd0, pc8}, 32'h0B);
        check("resume_mem1d", {24'd0, mem8[5'h1D]}, 32'h5A);
        queue_drained("resume");

        // 5. Reset during a stalled EXEC read
        reset8();
        mem8[0] = 8'h5E;      // ADD 0x1E
        mem8[1] = 8'h5E;      // ADD 0x1E
        mem8[2] = 8'hBF;      // LDA 0x1F  (ack withheld)
        mem8[5'h1E] = 8'hFF;
        mem8[5'h1F] = 8'h33;
        push_f(10'h0); push_r(10'h1E); push_f(10'h1); push_r(10'h1E); push_f(10'h2);
        blk_addr = 5'h1F;
        blk_en   = 1'b1;
        rst8 = 1'b0;
        n = 0;
        while (!(req8 && !we8 && addr8 == 5'h1F) && n < 50) begin
            tick();
            n++;
        end
        check("mid_stall_reached", {31'd0, (n < 50)}, 32'd1);
        tick();
        tick();
        check("mid_carry_before", {31'd0, carry8}, 32'd1);
        queue_drained("mid");
        rst8 = 1'b1;
        #1;
        check("mid_req_during_rst", {31'd0, req8}, 32'd0);
        tick();
        check("mid_req_after", {31'd0, req8}, 32'd0);
        check("mid_pc_after", {27'd0, pc8}, 32'd0);
        check("mid_carry_after", {31'd0, carry8}, 32'd0);
        blk_en = 1'b0;
        for (int i = 0; i < 32; i++) mem8[i] = 8'h00;
        mem8[0] = 8'hDD;      // STO 0x1D -> shows AC was cleared
        mem8[1] = 8'h00;      // HLT
        mem8[5'h1D] = 8'hAA;
        push_f(10'h0); push_w(10'h1D, 16'h0000); push_f(10'h1);
        rst8 = 1'b0;
        wait_halt8("mid_after", 50);
        check("mid_mem1d", {24'd0, mem8[5'h1D]}, 32'h00);
        check("mid_pc_final", {27'd0, pc8}, 32'd2);
        queue_drained("mid_after");

        // 6. Wide configuration: PC wrap, ADD carry, SKZ after zero result
        rst8  = 1'b1;
        rst16 = 1'b1;
        tick();
        tick();
        check("w_rst_pc", {22'd0, pc16}, 32'h3FD);
        for (int i = 0; i < 1024; i++) mem16[i] = 16'h0000;
        mem16[10'h3FD] = 16'hA100;  // LDA 0x100
        mem16[10'h3FE] = 16'h4101;  // ADD 0x101
        mem16[10'h3FF] = 16'h2000;  // SKZ
        mem16[10'h000] = 16'hE200;  // JMP 0x200 (skipped)
        mem16[10'h001] = 16'hC102;  // STO 0x102
        mem16[10'h002] = 16'h0000;  // HLT
        mem16[10'h100] = 16'hFFFF;
        mem16[10'h101] = 16'h0001;
        mem16[10'h102] = 16'hBEEF;
        push_f(10'h3FD); push_r(10'h100); push_f(10'h3FE); push_r(10'h101);
        push_f(10'h3FF); push_f(10'h001); push_w(10'h102, 16'h0000); push_f(10'h002);
        rst16 = 1'b0;
        n = 0;
        while (!halt16 && n < 100) begin
            tick();
            n++;
        end
        check("w_halt_reached", {31'd0, halt16}, 32'd1);
        check("w_carry", {31'd0, carry16}, 32'd1);
        check("w_pc", {22'd0, pc16}, 32'h003);
        check("w_mem102", {16'd0, mem16[10'h102]}, 32'h0000);
        queue_drained("wide");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout actual running required finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

endmodule
